sync_fifo: RTL and testbench

Parametrised single-clock FIFO. Successor to the team's simple dual-port RAM: it wraps that storage style with pointers, occupancy tracking, status flags and error strobes. It buffers symbol or sample streams between datapath stages in the Chapter1 communication chain. Depth is 2**ADDR_WIDTH words. Read latency is 1 cycle in standard mode, with an optional first-word-fall-through (FWFT) mode.

---
 rtl/sync_fifo_pkg.sv | 30 +++
 rtl/sdp_ram.sv | 23 ++
 rtl/sync_fifo.sv | 169 ++++++++++++++++
 tb/tb_sync_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo shared definitions: defaults, depth derivation, pointer type
// and compile-time checks on the almost-full / almost-empty levels.
package sync_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  localparam int DEF_DEPTH = fifo_depth(ADDR_WIDTH_DEF);

  // One extra MSB is the wrap bit
  typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

  function automatic bit levels_ok(input int aw, input int af,
                                   input int ae);
    return (af >= 0) && (af <= fifo_depth(aw)) &&
           (ae >= 0) && (ae < fifo_depth(aw));
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with
// read enable. Storage and read register are not reset.
module sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO over sdp_ram with registered flags, count and error
// strobes. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  typedef logic [ADDR_WIDTH:0] fptr_t;
  typedef logic [ADDR_WIDTH:0] cnt_t;

  if (!levels_ok(ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_lvl
    $error("sync_fifo: AF_LEVEL/AE_LEVEL out of range");
  end

  fptr_t wr_ptr_q, wr_ptr_d;
  fptr_t rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  logic  full_q, full_d;
  logic  af_q, af_d;
  logic  ae_q, ae_d;
  logic  ovf_q, ovf_d;
  logic  unf_q, unf_d;
  logic  wr_acc, ram_re, pop;
  logic  [DATA_WIDTH-1:0] ram_dout;

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata(wr_data),
    .re   (ram_re),
    .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata(ram_dout)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // ram_dout acts as a pending slot feeding the head register
  logic head_v_q, head_v_d;
  logic pend_v_q, pend_v_d;
  logic take, ram_empty;
  logic [DATA_WIDTH-1:0] head_q, head_d;

  always_comb begin
    ram_empty = (wr_ptr_q == rd_ptr_q);
    pop       = rd_en && head_v_q;
    take      = pend_v_q && (!head_v_q || pop);
    ram_re    = !ram_empty && (!pend_v_q || take);
    head_v_d  = take || (head_v_q && !pop);
    head_d    = take ? ram_dout : head_q;
    pend_v_d  = ram_re || (pend_v_q && !take);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_v_q <= 1'b0;
      pend_v_q <= 1'b0;
      head_q   <= '0;
    end else begin
      head_v_q <= head_v_d;
      pend_v_q <= pend_v_d;
      head_q   <= head_d;
    end
  end

  assign empty    = !head_v_q;
  assign rd_valid = head_v_q;
  assign rd_data  = head_q;
`else
  logic empty_q, empty_d;
  logic rd_valid_q, rd_valid_d;
  logic seen_q, seen_d;

  always_comb begin
    ram_re     = rd_en && !empty_q;
    pop        = ram_re;
    rd_valid_d = ram_re;
    seen_d     = seen_q || ram_re;
    empty_d    = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
      seen_q     <= seen_d;
    end
  end

  // Unreset RAM register is masked until the first read after reset
  assign empty    = empty_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = seen_q ? ram_dout : '0;
`endif

  always_comb begin
    wr_acc   = wr_en && !full_q;
    wr_ptr_d = wr_ptr_q + fptr_t'(wr_acc);
    rd_ptr_d = rd_ptr_q + fptr_t'(ram_re);
    count_d  = count_q + cnt_t'(wr_acc) - cnt_t'(pop);
`ifdef SYNC_FIFO_FWFT_EN
    full_d   = (count_d == cnt_t'(DEPTH));
`else
    full_d   = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
               (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
`endif
    af_d     = (count_d >= cnt_t'(AF_LEVEL));
    ae_d     = (count_d <= cnt_t'(AE_LEVEL));
    ovf_d    = wr_en && full_q;
    unf_d    = rd_en && empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed checks of sync_fifo (standard mode) against a
// queue-based reference model.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int AF = 60;
  localparam int AE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, almost_full, overflow;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, almost_empty, underflow;
  logic [AW:0]   count;

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .almost_empty(almost_empty),
    .underflow   (underflow),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"}, count, sz);
    chk({tag, ".full"}, full, sz == DEPTH);
    chk({tag, ".afull"}, almost_full, sz >= AF);
    chk({tag, ".empty"}, empty, sz == 0);
    chk({tag, ".aempty"}, almost_empty, sz <= AE);
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".unf"}, underflow, m_unf);
    chk({tag, ".rvalid"}, rd_valid, m_valid);
    chk({tag, ".rdata"}, rd_data, m_last);
  endtask

  // One clock: drive, model the edge from pre-edge state, check at negedge
  task automatic step(input string tag, input logic we,
                      input logic [DW-1:0] wd, input logic re);
    bit pre_full, pre_empty;
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    @(posedge clk);
    pre_full = (mq.size() == DEPTH);
    pre_empty = (mq.size() == 0);
    m_ovf = we && pre_full;
    m_unf = re && pre_empty;
    m_valid = re && !pre_empty;
    if (m_valid) m_last = mq.pop_front();
    if (we && !pre_full) mq.push_back(wd);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_all(tag);
  endtask

  // Reset pulse between clock edges; outputs must clear without an edge
  task automatic pulse_rst(input string tag);
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    m_last = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] d;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_all("reset");

    step("pre", 1'b1, 8'h31, 1'b0);
    step("pre", 1'b1, 8'h32, 1'b0);
    step("pre", 1'b0, 8'h00, 1'b1);
    chk("pre.valid_seen", rd_valid, 1'b1);
    pulse_rst("arst");
    step("a5", 1'b1, 8'hA5, 1'b0);
    step("a5", 1'b0, 8'h00, 1'b1);
    chk("a5.data", rd_data, 8'hA5);
    step("a5", 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, DW'(i), 1'b0);
    chk("fill.full", full, 1'b1);
    step("ovf", 1'b1, 8'h40, 1'b0);
    chk("ovf.strobe", overflow, 1'b1);
    step("ovf_end", 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1);
    chk("drain.empty", empty, 1'b1);
    step("unf", 1'b0, 8'h00, 1'b1);
    chk("unf.strobe", underflow, 1'b1);

    d = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step("wrap_pre", 1'b1, d, 1'b0);
      d++;
    end
    for (int i = 0; i < 200; i++) begin
      step("wrap", 1'b1, d, 1'b1);
      d++;
    end
    chk("wrap.count", count, 10);
    while (mq.size() != 0) step("wrap_drain", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("bfill", 1'b1, DW'(i + 7), 1'b0);
    step("b_full_rw", 1'b1, 8'hEE, 1'b1);
    chk("b_full.count", count, 63);
    chk("b_full.ovf", overflow, 1'b1);
    while (mq.size() != 0) step("bdrain", 1'b0, 8'h00, 1'b1);
    step("b_empty_rw", 1'b1, 8'h5A, 1'b1);
    chk("b_empty.count", count, 1);
    chk("b_empty.unf", underflow, 1'b1);
    step("b_empty_rd", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 400; i++)
      step("rnd_w", $urandom_range(0, 99) < 65, DW'($urandom),
           $urandom_range(0, 99) < 40);
    for (int i = 0; i < 400; i++)
      step("rnd_r", $urandom_range(0, 99) < 40, DW'($urandom),
           $urandom_range(0, 99) < 65);

    while (mq.size() > 30) step("mid_dn", 1'b0, 8'h00, 1'b1);
    while (mq.size() < 30) step("mid_up", 1'b1, DW'($urandom), 1'b0);
    chk("mid.count30", count, 30);
    pulse_rst("mrst");
    step("m11", 1'b1, 8'h11, 1'b0);
    step("m22", 1'b1, 8'h22, 1'b0);
    step("mrd", 1'b0, 8'h00, 1'b1);
    chk("mrd.11", rd_data, 8'h11);
    step("mrd", 1'b0, 8'h00, 1'b1);
    chk("mrd.22", rd_data, 8'h22);
    step("mend", 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
